// File: rtl/stream_shift_reg_pkg.sv
// Shared helpers for the elastic shift register.
// Only sizing arithmetic lives here; the payload type comes from the instantiator.
package stream_shift_reg_pkg;

    // Occupancy counter width: enough to hold 0..depth, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_shift_reg_stage.sv
// One stage of the elastic delay line: a valid bit plus a data register.
// The stage loads whenever it is empty or its content moves on this cycle.
module stream_shift_reg_stage
    import stream_shift_reg_pkg::*;
#(
    parameter type dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic src_valid_i,
    input  dtype src_data_i,
    input  logic dn_load_i,
    output logic load_o,
    output logic valid_o,
    output dtype data_o
);

    logic valid_d, valid_q;
    dtype data_d, data_q;

    // dn_load_i already implies the downstream took our item, so it alone frees us.
    assign load_o  = !valid_q | dn_load_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_o) begin
            valid_d = src_valid_i;
            // Bubbles leave the data register untouched to avoid needless toggling.
            if (src_valid_i) data_d = src_data_i;
        end
        if (flush_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/stream_shift_reg.sv
// Elastic Depth-stage delay line with valid/ready on both sides, flush and occupancy.
// Depth==0 degenerates to a combinational pass-through with no state.
module stream_shift_reg
    import stream_shift_reg_pkg::*;
#(
    parameter type         dtype    = logic,
    parameter int unsigned Depth    = 1,
    localparam int         CntWidth = int'(cnt_width(Depth))
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  dtype                data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output dtype                data_o,
    output logic [CntWidth-1:0] usage_o
);

    if (Depth == 0) begin : g_bypass
        logic unused_clk_rst;

        assign unused_clk_rst = clk_i ^ rst_ni;
        assign valid_o        = valid_i & !flush_i;
        assign ready_o        = ready_i & !flush_i;
        assign data_o         = data_i;
        assign usage_o        = '0;
    end else begin : g_pipe
        localparam int LastIdx = int'(Depth) - 1;

        logic                accept, deliver;
        logic [CntWidth-1:0] usage_d, usage_q;

        // The ready chain runs combinationally from ready_i back to stage 0.
        for (genvar k = 0; k < int'(Depth); k++) begin : g_stage
            logic src_valid, dn_load, load, valid;
            dtype src_data, data;

            if (k == 0) begin : g_head
                assign src_valid = accept;
                assign src_data  = data_i;
            end else begin : g_body
                assign src_valid = g_stage[k-1].valid;
                assign src_data  = g_stage[k-1].data;
            end

            if (k == LastIdx) begin : g_tail
                assign dn_load = ready_i;
            end else begin : g_link
                assign dn_load = g_stage[k+1].load;
            end

            stream_shift_reg_stage #(
                .dtype (dtype)
            ) u_stage (
                .clk_i       (clk_i),
                .rst_ni      (rst_ni),
                .flush_i     (flush_i),
                .src_valid_i (src_valid),
                .src_data_i  (src_data),
                .dn_load_i   (dn_load),
                .load_o      (load),
                .valid_o     (valid),
                .data_o      (data)
            );
        end

        assign ready_o = g_stage[0].load & !flush_i;
        assign valid_o = g_stage[LastIdx].valid;
        assign data_o  = g_stage[LastIdx].data;
        assign accept  = valid_i & ready_o;
        assign deliver = valid_o & ready_i;
        assign usage_o = usage_q;

        // A delivery during flush is legal; the count still returns to zero.
        always_comb begin
            usage_d = usage_q;
            if (flush_i)
                usage_d = '0;
            else if (accept && !deliver)
                usage_d = usage_q + CntWidth'(1);
            else if (!accept && deliver)
                usage_d = usage_q - CntWidth'(1);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) usage_q <= '0;
            else         usage_q <= usage_d;
        end
    end

endmodule
